// File: rtl/axi_switches_slave.sv
// AXI4-Lite register block for the switches peripheral: four scratch registers,
// synchronized switch status, sticky W1C change flags, IRQ enable and a level irq.
module axi_switches_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int NUM_SWITCHES       = 8
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [NUM_SWITCHES-1:0]         switches,
  output logic                            irq
);

  localparam int DW  = C_S_AXI_DATA_WIDTH;
  localparam int NB  = DW / 8;
  localparam int NSW = NUM_SWITCHES;

  localparam logic [2:0] IDX_SW_STATUS = 3'd4;
  localparam logic [2:0] IDX_SW_CHANGE = 3'd5;
  localparam logic [2:0] IDX_IRQ_EN    = 3'd6;

  // Handshake state
  logic           ready_en_q;
  logic           aw_full_q;
  logic [2:0]     aw_idx_q;
  logic           w_full_q;
  logic [DW-1:0]  wdata_q;
  logic [NB-1:0]  wstrb_q;
  logic           bvalid_q;
  logic           rvalid_q;
  logic [DW-1:0]  rdata_q;

  // Register file and switch pipeline
  logic [DW-1:0]  scratch_q [4];
  logic [NSW-1:0] irq_en_q, irq_en_d;
  logic [NSW-1:0] sw_change_q, sw_change_d;
  logic [NSW-1:0] sw_meta_q, sw_sync_q, sw_prev_q;
  logic [1:0]     arm_q;
  logic           irq_q;

  logic           aw_hs, w_hs, ar_hs, commit;
  logic [DW-1:0]  bit_en;
  logic [DW-1:0]  rd_mux;
  logic [DW-1:0]  sw_status_ext, sw_change_ext, irq_en_ext;
  logic [NSW-1:0] chg_set, chg_clr;
  logic           unused_inputs;

  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Ready flags stay low while in reset and rise the cycle after release.
  assign S_AXI_AWREADY = ready_en_q && !aw_full_q && !bvalid_q;
  assign S_AXI_WREADY  = ready_en_q && !w_full_q && !bvalid_q;
  assign S_AXI_ARREADY = ready_en_q && !rvalid_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign irq           = irq_q;

  assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign commit = aw_full_q && w_full_q && !bvalid_q;

  for (genvar gi = 0; gi < NB; gi++) begin : g_bit_en
    assign bit_en[gi*8 +: 8] = {8{wstrb_q[gi]}};
  end

  always_comb begin
    sw_status_ext = '0;
    sw_change_ext = '0;
    irq_en_ext    = '0;
    sw_status_ext[NSW-1:0] = sw_sync_q;
    sw_change_ext[NSW-1:0] = sw_change_q;
    irq_en_ext[NSW-1:0]    = irq_en_q;
    rd_mux = '0;
    case (S_AXI_ARADDR[4:2])
      3'd0, 3'd1, 3'd2, 3'd3: rd_mux = scratch_q[S_AXI_ARADDR[3:2]];
      IDX_SW_STATUS:          rd_mux = sw_status_ext;
      IDX_SW_CHANGE:          rd_mux = sw_change_ext;
      IDX_IRQ_EN:             rd_mux = irq_en_ext;
      default:                rd_mux = '0;
    endcase
  end

  // A change detected in the same cycle as a W1C clear of that bit survives.
  always_comb begin
    chg_clr = '0;
    chg_set = '0;
    irq_en_d = irq_en_q;
    if (commit && aw_idx_q == IDX_SW_CHANGE)
      chg_clr = wdata_q[NSW-1:0] & bit_en[NSW-1:0];
    if (commit && aw_idx_q == IDX_IRQ_EN)
      irq_en_d = (irq_en_q & ~bit_en[NSW-1:0]) | (wdata_q[NSW-1:0] & bit_en[NSW-1:0]);
    if (arm_q == 2'd3)
      chg_set = sw_sync_q ^ sw_prev_q;
    sw_change_d = (sw_change_q & ~chg_clr) | chg_set;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ready_en_q <= 1'b0;
      aw_full_q  <= 1'b0;
      aw_idx_q   <= '0;
      w_full_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      ready_en_q <= 1'b1;
      if (aw_hs) begin
        aw_full_q <= 1'b1;
        aw_idx_q  <= S_AXI_AWADDR[4:2];
      end
      if (w_hs) begin
        w_full_q <= 1'b1;
        wdata_q  <= S_AXI_WDATA;
        wstrb_q  <= S_AXI_WSTRB;
      end
      if (commit) begin
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
        bvalid_q  <= 1'b1;
      end else if (bvalid_q && S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
      if (ar_hs) begin
        rdata_q  <= rd_mux;
        rvalid_q <= 1'b1;
      end else if (rvalid_q && S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < 4; i++) scratch_q[i] <= '0;
      irq_en_q    <= '0;
      sw_change_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (commit && aw_idx_q == 3'(i))
          scratch_q[i] <= (scratch_q[i] & ~bit_en) | (wdata_q & bit_en);
      end
      irq_en_q    <= irq_en_d;
      sw_change_q <= sw_change_d;
      irq_q       <= |(sw_change_q & irq_en_q);
    end
  end

  // Arm counter masks the synchronizer filling with power-up switch levels.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      sw_prev_q <= '0;
      arm_q     <= 2'd0;
    end else begin
      sw_meta_q <= switches;
      sw_sync_q <= sw_meta_q;
      sw_prev_q <= sw_sync_q;
      if (arm_q != 2'd3)
        arm_q <= arm_q + 2'd1;
    end
  end

endmodule

// File: tb/tb_axi_switches_slave.sv
// Self-checking bench for axi_switches_slave: directed scenarios followed by
// random register traffic checked against a behavioural register model.
module tb_axi_switches_slave;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [4:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        AWREADY;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        bready;
  logic [4:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        rready;
  logic [7:0]  switches;
  logic        irq;

  always #5 ACLK = ~ACLK;

  axi_switches_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(5),
    .NUM_SWITCHES(8)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(AWREADY),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(WREADY),
    .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(ARREADY),
    .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(rready),
    .switches(switches), .irq(irq)
  );

  int total = 0;
  int bad   = 0;

  // Reference model of the programmer-visible state
  logic [31:0] m_scr [4];
  logic [7:0]  m_en, m_chg, m_status;
  logic        irq_at_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a[4:2])
      3'd0, 3'd1, 3'd2, 3'd3: return m_scr[a[3:2]];
      3'd4:    return {24'b0, m_status};
      3'd5:    return {24'b0, m_chg};
      3'd6:    return {24'b0, m_en};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    case (a[4:2])
      3'd0, 3'd1, 3'd2, 3'd3: m_scr[a[3:2]] = (m_scr[a[3:2]] & ~m) | (d & m);
      3'd5: m_chg = m_chg & ~(d[7:0] & m[7:0]);
      3'd6: m_en = (m_en & ~m[7:0]) | (d[7:0] & m[7:0]);
      default: ;
    endcase
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_scr[i] = 32'h0;
    m_en  = 8'h0;
    m_chg = 8'h0;
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    bit aw_done, w_done, aw_f, w_f, got;
    int cyc;
    @(negedge ACLK);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    aw_done = 0; w_done = 0; got = 0; cyc = 0; resp = 2'bxx;
    while (!(aw_done && w_done) && cyc < 50) begin
      aw_f = awvalid && AWREADY;
      w_f  = wvalid && WREADY;
      @(posedge ACLK); #1;
      if (aw_f) begin aw_done = 1; awvalid = 1'b0; end
      if (w_f)  begin w_done = 1;  wvalid = 1'b0; end
      @(negedge ACLK); cyc++;
    end
    while (!got && cyc < 100) begin
      if (BVALID) begin resp = BRESP; irq_at_b = irq; got = 1; end
      @(posedge ACLK); #1;
      if (!got) begin @(negedge ACLK); cyc++; end
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    chk("wr_timeout", {31'b0, !got}, 32'h0);
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit done, got;
    int cyc;
    @(negedge ACLK);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    done = 0; got = 0; cyc = 0; d = 'x; resp = 2'bxx;
    while (!done && cyc < 50) begin
      if (ARREADY) done = 1;
      @(posedge ACLK); #1;
      if (done) arvalid = 1'b0;
      @(negedge ACLK); cyc++;
    end
    while (!got && cyc < 100) begin
      if (RVALID) begin d = RDATA; resp = RRESP; got = 1; end
      @(posedge ACLK); #1;
      if (!got) begin @(negedge ACLK); cyc++; end
    end
    arvalid = 1'b0; rready = 1'b0;
    chk("rd_timeout", {31'b0, !got}, 32'h0);
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [1:0] r;
    axi_write(a, d, s, r);
    model_write(a, d, s);
    chk("bresp", {30'b0, r}, 32'h0);
    $display("WR addr=0x%02h data=0x%08h strb=%b resp=%0d", a, d, s, r);
  endtask

  task automatic do_read(input logic [4:0] a);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(a, d, r);
    chk("rdata", d, model_read(a));
    chk("rresp", {30'b0, r}, 32'h0);
    $display("RD addr=0x%02h data=0x%08h exp=0x%08h resp=%0d", a, d, model_read(a), r);
  endtask

  task automatic set_switches(input logic [7:0] v);
    @(negedge ACLK);
    switches = v;
    repeat (6) @(negedge ACLK);
    m_chg = m_chg | (m_status ^ v);
    m_status = v;
    $display("SW switches=0x%02h", v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd_exp;
    int op;
    logic [4:0]  ra;

    ARESET = 1'b1; awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0;
    wvalid = 1'b0; bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    switches = 8'h00; irq_at_b = 1'b0; m_status = 8'h00;
    model_reset();

    // Step 1: reset, then scratch write/readback
    repeat (20) @(negedge ACLK);
    chk("rst_awready", {31'b0, AWREADY}, 32'h0);
    chk("rst_wready",  {31'b0, WREADY},  32'h0);
    chk("rst_arready", {31'b0, ARREADY}, 32'h0);
    chk("rst_bvalid",  {31'b0, BVALID},  32'h0);
    chk("rst_rvalid",  {31'b0, RVALID},  32'h0);
    chk("rst_rdata",   RDATA,            32'h0);
    chk("rst_irq",     {31'b0, irq},     32'h0);
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("post_rst_awready", {31'b0, AWREADY}, 32'h1);
    chk("post_rst_wready",  {31'b0, WREADY},  32'h1);
    chk("post_rst_arready", {31'b0, ARREADY}, 32'h1);
    for (int i = 0; i < 4; i++) do_write(5'(i * 4), 32'(i + 1), 4'hF);
    for (int i = 0; i < 4; i++) begin
      do_read(5'(i * 4));
    end
    chk("scratch3_const", model_read(5'h0C), 32'h4);

    // Step 2: partial byte strobes
    do_write(5'h00, 32'hAABBCCDD, 4'b0101);
    do_read(5'h00);
    chk("strobe_const", model_read(5'h00), 32'h00BB00DD);

    // Step 3: W three cycles ahead of AW
    @(negedge ACLK);
    chk("s3_wready_pre", {31'b0, WREADY}, 32'h1);
    awaddr = 5'h04; wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    @(posedge ACLK); #1; wvalid = 1'b0;
    @(negedge ACLK);
    chk("s3_wready_after_w", {31'b0, WREADY}, 32'h0);
    chk("s3_awready_wait",   {31'b0, AWREADY}, 32'h1);
    chk("s3_bvalid_early",   {31'b0, BVALID}, 32'h0);
    @(posedge ACLK); @(posedge ACLK); #1; awvalid = 1'b1;
    @(negedge ACLK);
    chk("s3_awready", {31'b0, AWREADY}, 32'h1);
    @(posedge ACLK); #1; awvalid = 1'b0;
    @(negedge ACLK);
    chk("s3_bvalid_edge1", {31'b0, BVALID}, 32'h0);
    @(negedge ACLK);
    chk("s3_bvalid_edge2", {31'b0, BVALID}, 32'h1);
    chk("s3_bresp", {30'b0, BRESP}, 32'h0);
    bready = 1'b1;
    @(negedge ACLK);
    chk("s3_bvalid_done", {31'b0, BVALID}, 32'h0);
    bready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      chk("s3_bvalid_quiet", {31'b0, BVALID}, 32'h0);
    end
    model_write(5'h04, 32'hDEADBEEF, 4'hF);
    $display("WR addr=0x04 data=0xdeadbeef W-before-AW");
    do_read(5'h04);

    // Step 4: switches, change flags and interrupt
    set_switches(8'hA5);
    do_read(5'h10);
    do_read(5'h14);
    chk("s4_chg_const", model_read(5'h14), 32'hA5);
    @(negedge ACLK);
    chk("s4_irq_off", {31'b0, irq}, 32'h0);
    do_write(5'h18, 32'h00000001, 4'hF);
    chk("s4_irq_at_b", {31'b0, irq_at_b}, 32'h0);
    @(negedge ACLK);
    chk("s4_irq_on", {31'b0, irq}, 32'h1);
    do_write(5'h14, 32'h00000001, 4'hF);
    do_read(5'h14);
    chk("s4_chg_w1c_const", model_read(5'h14), 32'hA4);
    @(negedge ACLK);
    chk("s4_irq_cleared", {31'b0, irq}, 32'h0);
    do_read(5'h18);

    // Step 5: back-pressure on both response channels
    @(negedge ACLK);
    awaddr = 5'h08; wdata = 32'h13572468; wstrb = 4'hF; araddr = 5'h04;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
    rd_exp = model_read(5'h04);
    @(posedge ACLK); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    model_write(5'h08, 32'h13572468, 4'hF);
    @(posedge ACLK); #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK);
      chk("s5_bvalid_hold", {31'b0, BVALID}, 32'h1);
      chk("s5_rvalid_hold", {31'b0, RVALID}, 32'h1);
      chk("s5_rdata_hold",  RDATA, rd_exp);
      chk("s5_readies", {29'b0, AWREADY, WREADY, ARREADY}, 32'h0);
    end
    rready = 1'b1;
    @(negedge ACLK);
    rready = 1'b0;
    chk("s5_rvalid_done", {31'b0, RVALID}, 32'h0);
    chk("s5_arready_back", {31'b0, ARREADY}, 32'h1);
    chk("s5_bvalid_still", {31'b0, BVALID}, 32'h1);
    chk("s5_awready_still", {31'b0, AWREADY}, 32'h0);
    bready = 1'b1;
    @(negedge ACLK);
    bready = 1'b0;
    chk("s5_bvalid_done", {31'b0, BVALID}, 32'h0);
    chk("s5_wr_readies", {30'b0, AWREADY, WREADY}, 32'h3);
    $display("WR+RD back-pressure rdata=0x%08h", rd_exp);
    do_read(5'h08);

    // Step 6: reset with a write response pending
    @(negedge ACLK);
    awaddr = 5'h0C; wdata = 32'h00000055; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(posedge ACLK); #1; awvalid = 1'b0; wvalid = 1'b0;
    @(negedge ACLK); @(negedge ACLK);
    chk("s6_bvalid_pending", {31'b0, BVALID}, 32'h1);
    ARESET = 1'b1;
    @(negedge ACLK);
    chk("s6_bvalid_dropped", {31'b0, BVALID}, 32'h0);
    chk("s6_awready_rst", {31'b0, AWREADY}, 32'h0);
    chk("s6_irq_rst", {31'b0, irq}, 32'h0);
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    model_reset();
    $display("RST during pending B");
    repeat (6) @(negedge ACLK);
    chk("s6_bvalid_after", {31'b0, BVALID}, 32'h0);
    for (int i = 0; i < 4; i++) do_read(5'(i * 4));
    do_read(5'h14);
    do_read(5'h1C);
    do_write(5'h10, 32'hFFFFFFFF, 4'hF);
    do_read(5'h10);
    chk("s6_status_const", model_read(5'h10), 32'hA5);

    // Random traffic against the model
    for (int n = 0; n < 80; n++) begin
      op = $urandom_range(0, 9);
      ra = 5'($urandom_range(0, 31));
      if (op < 2) set_switches(8'($urandom_range(0, 255)));
      else if (op < 6) do_write(ra, $urandom, 4'($urandom_range(0, 15)));
      else do_read(ra);
      @(negedge ACLK);
      chk("rand_irq", {31'b0, irq}, {31'b0, |(m_chg & m_en)});
    end
    for (int i = 0; i < 8; i++) do_read(5'(i * 4));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_switches_slave.md
Name: axi_switches_slave

Overview:
AXI4-Lite slave (responder) register block for the switches peripheral. It accepts single-beat reads and writes from the PS/VIP master. It provides four general-purpose scratch registers, a synchronized switch status register, sticky change flags, and an interrupt enable. It drives a level interrupt to the interrupt controller.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 5, byte address width; 8 word registers.
NUM_SWITCHES, 8, switch input width; 1..32.

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous reset, active-high
S_AXI_AWADDR  in  5  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write address handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID / S_AXI_WREADY  in/out  1  write data handshake
S_AXI_BRESP  out  2  always 2'b00 (OKAY)
S_AXI_BVALID / S_AXI_BREADY  out/in  1  write response handshake
S_AXI_ARADDR  in  5  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read address handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  always 2'b00
S_AXI_RVALID / S_AXI_RREADY  out/in  1  read data handshake
switches  in  NUM_SWITCHES  asynchronous switch inputs
irq  out  1  registered interrupt, active-high

Behaviour:
- Reset (ARESET=1 at a rising edge):
  - All outputs 0 except AWREADY, WREADY and ARREADY, which read 1 from the cycle after reset release.
  - All registers, sync flops and capture flags clear; the arm counter returns to 0.
  - Reset takes effect mid-transaction: pending B/R responses are dropped with no completion.
- Address map (decode on addr[4:2]; addr[1:0] ignored):
  - 0x00–0x0C: SCRATCH0–3, RW.
  - 0x10: SW_STATUS, RO; synchronized switch value, zero-extended.
  - 0x14: SW_CHANGE, W1C; sticky per-bit change flags.
  - 0x18: IRQ_EN, RW; low NUM_SWITCHES bits only, upper bits read 0.
  - 0x1C: reserved; reads 0, writes ignored, response OKAY.
- Write path; AW and W are captured independently, in either order:
  - AWREADY = !aw_full && !BVALID and WREADY = !w_full && !BVALID. Both are functions of registers only, with no combinational input-to-output paths.
  - On an AW handshake: latch the address and set aw_full. On a W handshake: latch data and strobe and set w_full.
  - At the first edge where aw_full && w_full && !BVALID: commit the write, set BVALID, and clear both full flags. BVALID is therefore high the 2nd edge after the later handshake.
  - BVALID holds until BREADY is sampled high; BVALID then deasserts. At most one write is outstanding.
  - SCRATCH and IRQ_EN update byte-wise per WSTRB. SW_CHANGE clears bits whose byte lane strobe is set and whose data bit is 1.
- Read path:
  - ARREADY = !RVALID.
  - On an AR handshake: register RDATA from the address mux and set RVALID at the same edge (1-cycle latency).
  - RVALID/RDATA hold stable until RREADY is sampled high. Reads have no side effects.
  - Read and write paths are fully independent and may complete on the same edge.
- Switch input:
  - Two-flop synchronizer feeds sw_sync; sw_prev tracks sw_sync every cycle.
  - A 2-bit arm counter saturates at 3 after reset. Change detection is enabled only at 3, so power-up switch levels raise no flags.
  - When armed, SW_CHANGE[i] is set when sw_sync[i] != sw_prev[i].
  - Set and W1C clear on the same bit in the same cycle: set wins.
- irq is registered each edge from the OR-reduction of (SW_CHANGE & IRQ_EN); one cycle of latency after either input updates.

Test Plan:
1. Reset 20 cycles, then write 0x1,0x2,0x3,0x4 to 0x00,0x04,0x08,0x0C, then read them back -> RDATA 0x1..0x4, all BRESP/RRESP 2'b00.
2. SCRATCH0=0x00000001; write 0xAABBCCDD with WSTRB=4'b0101 -> readback 0x00BB00DD.
3. WVALID asserted 3 cycles before AWVALID -> WREADY drops after W capture; exactly one BVALID pulse, 2 edges after the AW handshake; data correct.
4. Hold switches=0x00 through reset, then 0xA5 -> after ≥3 cycles SW_STATUS=0xA5 and SW_CHANGE=0xA5, irq=0.
   - Write IRQ_EN=0x01 -> irq=1 the cycle after the IRQ_EN update.
   - Write SW_CHANGE=0x01 -> SW_CHANGE=0xA4 and irq=0.
5. Hold BREADY=0 and RREADY=0 for 10 cycles after issuing a write and a read -> BVALID/RVALID and RDATA stay stable; AWREADY/WREADY/ARREADY stay 0 until each response is accepted.
6. Assert ARESET while BVALID is pending -> BVALID=0 and SCRATCH=0 on the next edge. Then read 0x1C -> 0x0 with OKAY, and write 0x10 -> SW_STATUS unchanged.
